// File: rtl/n_bit_adder.sv
// rtl/n_bit_adder.sv - parameterised ripple-carry adder with carry chain and registered result
module n_bit_adder #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         ci,
    output logic [N-1:0] S,
    output logic         co,
    output logic         ovf,
    output logic [N-1:0] S_q,
    output logic         co_q,
    output logic         ovf_q
);

    // c[i] is the carry into cell i; c[N] is the carry out of the MSB cell
    logic [N:0] c;

    assign c[0] = ci;

    // One full-adder cell per bit; the carry ripples LSB to MSB with no lookahead
    genvar i;
    generate
        for (i = 0; i < N; i++) begin : g_cell
            assign S[i]   = A[i] ^ B[i] ^ c[i];
            assign c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
        end
    endgenerate

    assign co = c[N];

    // Signed overflow: carry into the MSB disagrees with carry out of it.
    // For N = 1, c[N-1] is c[0], which is ci.
    assign ovf = c[N] ^ c[N-1];

    // Capture the combinational result every edge; reset clears it immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            S_q   <= '0;
            co_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            S_q   <= S;
            co_q  <= co;
            ovf_q <= ovf;
        end
    end

endmodule

// File: tb/tb_n_bit_adder.sv
// tb/tb_n_bit_adder.sv - scoreboard bench for n_bit_adder
module tb_n_bit_adder;

    localparam int N = 8;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         ci;
    logic [N-1:0] S;
    logic         co;
    logic         ovf;
    logic [N-1:0] S_q;
    logic         co_q;
    logic         ovf_q;

    int checks   = 0;
    int failures = 0;

    // expected {ovf, co, S}
    logic [N+1:0] comb_q[$];
    logic [N+1:0] reg_q[$];

    n_bit_adder #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .A     (A),
        .B     (B),
        .ci    (ci),
        .S     (S),
        .co    (co),
        .ovf   (ovf),
        .S_q   (S_q),
        .co_q  (co_q),
        .ovf_q (ovf_q)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [N+1:0] act, input logic [N+1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual={ovf,co,S}=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one vector at the falling edge and queue its expected response
    task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b, input logic c,
                         input logic [N+1:0] exp);
        @(negedge clk);
        A  = a;
        B  = b;
        ci = c;
        comb_q.push_back(exp);
        reg_q.push_back(exp);
    endtask

    // Combinational monitor: 1 ns after each drive point
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (comb_q.size() > 0) chk("comb", {ovf, co, S}, comb_q.pop_front());
        end
    end

    // Registered monitor: 1 ns after each capture edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (reg_q.size() > 0) chk("reg", {ovf_q, co_q, S_q}, reg_q.pop_front());
        end
    end

    initial begin
        logic [N-1:0] ra, rb;
        logic         rc;
        logic [N:0]   sum;
        logic         rovf;

        rst_n = 1'b0;
        A     = '0;
        B     = '0;
        ci    = 1'b0;

        // Reset state before any clock, and held across an edge
        #1;
        chk("reset_init", {ovf_q, co_q, S_q}, 10'h000);
        @(posedge clk);
        #1;
        chk("reset_hold_edge", {ovf_q, co_q, S_q}, 10'h000);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors, expected {ovf,co,S} computed by hand
        issue(8'h05, 8'h0A, 1'b0, {1'b0, 1'b0, 8'h0F});
        issue(8'h1E, 8'hF6, 1'b0, {1'b0, 1'b1, 8'h14});
        issue(8'h05, 8'h0A, 1'b1, {1'b0, 1'b0, 8'h10});
        issue(8'h7F, 8'h01, 1'b0, {1'b1, 1'b0, 8'h80});
        issue(8'hFF, 8'h00, 1'b1, {1'b0, 1'b1, 8'h00});
        issue(8'h80, 8'h80, 1'b0, {1'b1, 1'b1, 8'h00});
        issue(8'h80, 8'hFF, 1'b1, {1'b0, 1'b1, 8'h80});
        issue(8'h00, 8'h00, 1'b0, {1'b0, 1'b0, 8'h00});
        issue(8'hFF, 8'hFF, 1'b1, {1'b0, 1'b1, 8'hFF});

        // Random signed operands; expected from zero-extended sum and MSB overflow rule
        for (int k = 0; k < 12; k++) begin
            ra   = N'($urandom_range(0, 255));
            rb   = N'($urandom_range(0, 255));
            rc   = 1'($urandom_range(0, 1));
            sum  = {1'b0, ra} + {1'b0, rb} + {{N{1'b0}}, rc};
            rovf = (ra[N-1] == rb[N-1]) && (sum[N-1] != ra[N-1]);
            issue(ra, rb, rc, {rovf, sum});
        end

        // Reset mid-operation
        issue(8'h7F, 8'h01, 1'b0, {1'b1, 1'b0, 8'h80});
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("reset_async", {ovf_q, co_q, S_q}, 10'h000);
        chk("reset_comb_unaffected", {ovf, co, S}, {1'b1, 1'b0, 8'h80});
        @(posedge clk);
        #1;
        chk("reset_held_low", {ovf_q, co_q, S_q}, 10'h000);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_release_reload", {ovf_q, co_q, S_q}, {1'b1, 1'b0, 8'h80});

        // Drain with a bounded wait
        for (int w = 0; w < 10 && (comb_q.size() > 0 || reg_q.size() > 0); w++)
            @(posedge clk);
        #3;
        checks++;
        if (comb_q.size() != 0 || reg_q.size() != 0) begin
            failures++;
            $display("FAIL drain actual=%0d/%0d pending required=0/0", comb_q.size(), reg_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/n_bit_adder.md
# n_bit_adder

Parameterised N-bit ripple-carry adder with carry-in and carry-out. It produces a combinational sum and carry in the same delta as its inputs, plus a registered copy of sum, carry and signed-overflow flag for downstream synchronous logic. It is a leaf arithmetic block used wherever a plain two-operand add with carry chaining is needed, and it is chainable through `ci`/`co` for wider words.

## Interface
- `N`, default 8: operand and sum width in bits; legal N ≥ 1.
- `clk`  in  1  system clock; registered outputs update on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset; clears all registered outputs.
- `A`  in  N  operand A; two's-complement or unsigned, identical bit pattern.
- `B`  in  N  operand B; same encoding as A.
- `ci`  in  1  carry-in, weight 1.
- `S`  out  N  combinational sum, `(A + B + ci) mod 2^N`.
- `co`  out  1  combinational unsigned carry-out, bit N of the zero-extended sum.
- `ovf`  out  1  combinational signed overflow: A and B have equal MSBs and S MSB differs from them.
- `S_q`  out  N  registered S.
- `co_q`  out  1  registered co.
- `ovf_q`  out  1  registered ovf.

## Operation
- Core is a chain of N full-adder cells built with a generate loop.
  - Cell i: `s_i = a_i ^ b_i ^ c_i`, `c_{i+1} = a_i&b_i | c_i&(a_i^b_i)`.
  - `c_0 = ci`; `co = c_N`.
- `{co,S}` equals the (N+1)-bit unsigned sum of zero-extended A, zero-extended B and ci, for all 2^(2N+1) input combinations.
  - This holds even when the operands are interpreted as signed.
- `ovf = c_N ^ c_{N-1}`, equivalent to the MSB rule above.
  - For N = 1, `c_{N-1}` is ci.
- No internal state in the combinational path.
  - S, co and ovf are pure functions of the current A, B and ci.
  - They are independent of clk and rst_n.
- Registered stage: on each rising clk with rst_n high, `S_q <= S`, `co_q <= co`, `ovf_q <= ovf`.
- X/Z on any input may propagate to the outputs; no sanitising.

## Timing
- Combinational outputs: zero-cycle latency; valid within the same simulation time step as the input change.
  - The bench samples them 1 ns after driving inputs.
- Registered outputs: one-cycle latency; they reflect the inputs present at the preceding rising clk edge.
- Reset:
  - rst_n low immediately forces S_q = 0, co_q = 0, ovf_q = 0, without waiting for clk.
  - Assertion mid-operation discards the pending value.
  - The first rising edge after deassertion captures the current inputs.
  - Combinational outputs are unaffected by reset.
- No handshake; every clk edge is a capture.
- Critical path is the N-stage carry ripple; no pipelining inside the chain.

## Test plan
- A=5, B=10, ci=0 -> S=15, co=0, ovf=0; after next clk edge S_q=15, co_q=0.
- A=30, B=-10 (0xF6), ci=0 -> S=20 (0x14), co=1, ovf=0.
- A=5, B=10, ci=1 -> S=16, co=0, ovf=0.
- A=127, B=1, ci=0 -> S=0x80 (-128), co=0, ovf=1; A=0xFF, B=0x00, ci=1 -> S=0, co=1, ovf=0.
- 10+ random signed A, B in [-128, 127] with random ci: each must satisfy `{co,S} == zero-extended A + B + ci` 1 ns after drive, and `S_q/co_q/ovf_q` must match the sampled inputs one clk later.
- Reset: drive A=127, B=1, clock once (S_q=0x80, ovf_q=1), then pull rst_n low between edges. S_q, co_q and ovf_q must go to 0 at once and hold there while low. On release, the first edge reloads them from the current inputs.
